inst_mem: RTL and testbench

Instruction memory responder for the OpenMIPS core's fetch interface. It answers the core's `rom_ce_o`/`rom_addr_o` requests with a combinational 32-bit instruction word. It also owns a byte-stream loader that fills the memory after reset and holds the core in reset until the image is complete. It sits beside the core at SoC top level: `ce`/`addr` come from the core, `inst` feeds `rom_data_i`, and `cpu_rst_o` drives the core's `rst`.

---
 rtl/inst_mem.sv | 199 +++++++++++++++++++
 tb/tb_inst_mem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// inst_mem: instruction memory for the OpenMIPS fetch port, with a byte-stream
// loader that fills the array after reset and holds the core in reset until
// the image is complete.
//
// Optional feature macro: INST_MEM_CHECKSUM_EN (adds a trailing XOR checksum
// byte, a CHK state and a sticky ERR state).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ce         fetch enable from the core
//   addr       byte address from the core's PC
//   inst       instruction word (combinational)
//   ld_valid   loader byte valid
//   ld_byte    loader byte
//   ld_ready   loader can accept a byte (combinational from state)
//   reload     single-cycle pulse restarting the load
//   cpu_rst_o  registered reset to the core, high whenever not in RUN
//   err_o      registered checksum-error flag
module inst_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        reload,
  output logic        cpu_rst_o,
  output logic        err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;

`ifdef INST_MEM_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;
  localparam state_t LOAD_DONE = CHK;
`else
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    RUN    = 3'd4
  } state_t;
  localparam state_t LOAD_DONE = RUN;
`endif

  logic [31:0]      mem [DEPTH];

  state_t           state, state_d;
  logic [CNT_W-1:0] n_words, n_words_d;
  logic [CNT_W-1:0] waddr, waddr_d;
  logic [1:0]       byte_cnt, byte_cnt_d;
  logic [23:0]      word_acc, word_acc_d;
  logic             we;
  logic [31:0]      wdata;
  logic             take;
  logic             in_range;
`ifdef INST_MEM_CHECKSUM_EN
  logic [7:0]       csum, csum_d;
`endif

  // Byte-lane bits of the fetch address carry no information for word reads.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Loader handshake: open in every loading state.
  always_comb begin
    ld_ready = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA: ld_ready = 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      CHK:                  ld_ready = 1'b1;
`endif
      default:              ld_ready = 1'b0;
    endcase
  end

  assign take     = ld_valid && ld_ready;
  assign in_range = 32'(waddr) < DEPTH;

  // Next-state and datapath update for the loader.
  always_comb begin
    state_d    = state;
    n_words_d  = n_words;
    waddr_d    = waddr;
    byte_cnt_d = byte_cnt;
    word_acc_d = word_acc;
    we         = 1'b0;
    wdata      = {word_acc, ld_byte};
`ifdef INST_MEM_CHECKSUM_EN
    csum_d     = csum;
`endif
    if (reload) begin
      // Reload wins over any byte offered in the same cycle.
      state_d    = HDR_HI;
      waddr_d    = '0;
      byte_cnt_d = '0;
`ifdef INST_MEM_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else if (take) begin
      case (state)
        HDR_HI: begin
          n_words_d = {ld_byte, n_words[7:0]};
          state_d   = HDR_LO;
        end
        HDR_LO: begin
          n_words_d  = {n_words[15:8], ld_byte};
          waddr_d    = '0;
          byte_cnt_d = '0;
          if ({n_words[15:8], ld_byte} == 16'd0) state_d = LOAD_DONE;
          else                                    state_d = DATA;
        end
        DATA: begin
`ifdef INST_MEM_CHECKSUM_EN
          csum_d = csum ^ ld_byte;
`endif
          byte_cnt_d = 2'(byte_cnt + 2'd1);
          if (byte_cnt == 2'd3) begin
            // Words beyond the array are consumed and counted but dropped.
            we      = in_range;
            waddr_d = CNT_W'(waddr + 16'd1);
            if (CNT_W'(waddr + 16'd1) == n_words) state_d = LOAD_DONE;
          end else begin
            word_acc_d = {word_acc[15:0], ld_byte};
          end
        end
`ifdef INST_MEM_CHECKSUM_EN
        CHK: begin
          if (ld_byte == csum) state_d = RUN;
          else                 state_d = ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // Control registers; the core reset output tracks the next state so it
  // falls on the edge that completes the image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR_HI;
      n_words   <= '0;
      waddr     <= '0;
      byte_cnt  <= '0;
      word_acc  <= '0;
      cpu_rst_o <= 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_d;
      n_words   <= n_words_d;
      waddr     <= waddr_d;
      byte_cnt  <= byte_cnt_d;
      word_acc  <= word_acc_d;
      cpu_rst_o <= (state_d != RUN);
`ifdef INST_MEM_CHECKSUM_EN
      csum      <= csum_d;
`endif
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  // Error flag is set on entry to ERR and cleared by reload or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= 1'b0;
    else     err_o <= (state_d == ERR);
  end
`else
  assign err_o = 1'b0;
`endif

  // Memory array is deliberately not reset; contents survive reload and rst.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[ADDR_W'(waddr)] <= wdata;
  end

  // Zero-latency fetch, qualified by enable, RUN and address range.
  always_comb begin
    inst = '0;
    if (ce && (state == RUN) && (addr[31:ADDR_W+2] == '0))
      inst = mem[addr[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: randomized self-checking bench for inst_mem against a
// word-array model of the loaded image.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_ready;
  logic        reload = 1'b0;
  logic        cpu_rst_o;
  logic        err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_mem [1024];
  bit          known   [1024];
  logic [31:0] img     [2048];
  bit          running = 1'b0;

  inst_mem #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .reload(reload), .cpu_rst_o(cpu_rst_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    #1 check("ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #1 ld_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    running = 1'b0;
    check("cpu_rst_reload", 32'(cpu_rst_o), 32'd1);
    check("err_reload", 32'(err_o), 32'd0);
  endtask

  // Streams header, words from img[] and (if enabled) checksum; updates model.
  task automatic load_image(input int n, input bit corrupt, input bit expect_run);
    logic [7:0] q[$];
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < n; i++)
      for (int k = 3; k >= 0; k--) begin
        b = img[i][k*8 +: 8];
        q.push_back(b);
        x = x ^ b;
      end
`ifdef INST_MEM_CHECKSUM_EN
    q.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
    for (int i = 0; i < q.size(); i++) begin
      if (i != 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      if (i == q.size() - 1) check("cpu_rst_before_last", 32'(cpu_rst_o), 32'd1);
      send_byte(q[i]);
    end
    for (int i = 0; i < n && i < 1024; i++) begin
      exp_mem[i] = img[i];
      known[i]   = 1'b1;
    end
    if (expect_run) begin
      check("cpu_rst_after_load", 32'(cpu_rst_o), 32'd0);
      check("err_after_load", 32'(err_o), 32'd0);
      check("ld_ready_run", 32'(ld_ready), 32'd0);
      running = 1'b1;
    end else begin
      check("err_bad_csum", 32'(err_o), 32'd1);
      check("cpu_rst_bad_csum", 32'(cpu_rst_o), 32'd1);
      check("ld_ready_err", 32'(ld_ready), 32'd0);
      running = 1'b0;
    end
  endtask

  task automatic rd(input logic c, input logic [31:0] a);
    logic [31:0] e;
    bit skip;
    skip = 1'b0;
    e    = '0;
    @(negedge clk);
    ce   = c;
    addr = a;
    #1;
    if (c && running && a[31:12] == 20'd0) begin
      if (known[a[11:2]]) e = exp_mem[a[11:2]];
      else                skip = 1'b1;
    end
    if (!skip) check($sformatf("inst@%h", a), inst, e);
  endtask

  task automatic random_reads(input int cnt);
    logic [31:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 4095)) : $urandom;
      rd(1'($urandom_range(0, 7) != 0), a);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      exp_mem[i] = '0;
      known[i]   = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    ce = 1'b1;
    #1;
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_inst", inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;

    // Basic two-word image
    img[0] = 32'h34011100;
    img[1] = 32'h34020020;
    load_image(2, 1'b0, 1'b1);
    rd(1'b1, 32'h0);
    rd(1'b1, 32'h4);
    // Read qualification
    rd(1'b0, 32'h4);
    rd(1'b1, 32'h00001000);
    rd(1'b1, 32'h5);
    rd(1'b1, 32'h80000004);

    // Empty image; loader stays closed in RUN
    pulse_reload();
    rd(1'b1, 32'h4);
    load_image(0, 1'b0, 1'b1);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = 8'h12;
    for (int i = 0; i < 4; i++) begin
      #1 check("ld_ready_held", 32'(ld_ready), 32'd0);
      check("cpu_rst_held", 32'(cpu_rst_o), 32'd0);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rd(1'b1, 32'h4);

    // Reload with a one-word image; word 1 is retained
    pulse_reload();
    img[0] = 32'hAABBCCDD;
    load_image(1, 1'b0, 1'b1);
    rd(1'b1, 32'h0);
    rd(1'b1, 32'h4);

    // Random images
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      pulse_reload();
      load_image(n, 1'b0, 1'b1);
      random_reads(12);
      for (int i = 0; i < 8; i++) rd(1'b1, 32'(i * 4));
    end

    // Async reset while in RUN raises cpu_rst_o immediately
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_run", 32'(cpu_rst_o), 32'd1);
    check("async_rst_inst", inst, 32'd0);
    running = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset after 6 bytes of a two-word load: word 0 written, then restart
    img[0] = 32'h11223344;
    img[1] = 32'h55667788;
    send_byte(8'h00);
    send_byte(8'h02);
    for (int k = 3; k >= 0; k--) send_byte(img[0][k*8 +: 8]);
    exp_mem[0] = img[0];
    known[0]   = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_rst_load", 32'(cpu_rst_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    // Stray byte alongside reload must not be consumed
    @(negedge clk);
    reload   = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    @(posedge clk);
    #1 reload = 1'b0;
    ld_valid = 1'b0;
    img[0] = 32'hCAFEF00D;
    load_image(1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rd(1'b1, 32'(i * 4));

    // Overflow: words past the array are discarded, not aliased
    for (int i = 0; i < 1026; i++) img[i] = $urandom;
    pulse_reload();
    load_image(1026, 1'b0, 1'b1);
    rd(1'b1, 32'h0);
    rd(1'b1, 32'h4);
    rd(1'b1, 32'hFFC);
    rd(1'b1, 32'h1000);
    random_reads(24);

`ifdef INST_MEM_CHECKSUM_EN
    // Checksum mismatch then recovery
    img[0] = 32'h01020304;
    pulse_reload();
    load_image(1, 1'b1, 1'b0);
    rd(1'b1, 32'h0);
    pulse_reload();
    load_image(1, 1'b0, 1'b1);
    rd(1'b1, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
